// File: rtl/aib_redundancy_pkg.sv
// aib_redundancy_pkg: shared constants and FSM state type for the AIB redundancy controller.
//   NPADS/IDXW  : microbump count and pad index width
//   SPARE_*     : parity-matched spare bumps
//   LO_*/HI_*   : repairable pad ranges below and above the spares
package aib_redundancy_pkg;
    localparam int NPADS = 102;
    localparam int IDXW  = 7;
    localparam logic [IDXW-1:0] SPARE_EVEN = 7'd50;
    localparam logic [IDXW-1:0] SPARE_ODD  = 7'd51;
    localparam logic [IDXW-1:0] LO_MIN     = 7'd2;
    localparam logic [IDXW-1:0] LO_MAX     = 7'd49;
    localparam logic [IDXW-1:0] HI_MIN     = 7'd52;
    localparam logic [IDXW-1:0] HI_MAX     = 7'd101;
    typedef enum logic [2:0] {IDLE, CHECK, FILL, CLEAR, ACK} state_t;
endpackage

// File: rtl/aib_redundancy_ctrl.sv
// aib_redundancy_ctrl: builds the thermometer pad_shift repair vector for the AIB redundancy mux.
//   clk, rst_n        : block clock, asynchronous active-low reset
//   rep_req, rep_clr  : repair / clear-all requests, held until rep_ack
//   rep_idx           : failing pad index, sampled in IDLE
//   rep_ack, rep_err  : one-cycle completion strobe and reject flag
//   busy              : FSM not in IDLE
//   pad_shift         : registered repair vector
//   shift_valid       : pad_shift is not mid-fill
module aib_redundancy_ctrl
    import aib_redundancy_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             rep_req,
    input  logic             rep_clr,
    input  logic [IDXW-1:0]  rep_idx,
    output logic             rep_ack,
    output logic             rep_err,
    output logic             busy,
    output logic [NPADS-1:0] pad_shift,
    output logic             shift_valid
);
    state_t          state_q, state_d;
    logic [IDXW-1:0] idx_q, ptr_q, end_q, start, stop;
    logic [1:0]      used_q;
    logic            err_q, hold_q, go, bad, lower;

    // hold_q blocks a request that is still asserted after its own ack,
    // so the requester must drop req/clr for a cycle before the next one.
    assign go    = !hold_q && (rep_req || rep_clr);
    assign bad   = (idx_q <= 7'd1) || (idx_q == SPARE_EVEN) || (idx_q == SPARE_ODD) ||
                   (idx_q > HI_MAX) || used_q[idx_q[0]];
    assign lower = idx_q <= LO_MAX;
    // Lower faults shift toward the spare (up to 48/49); upper faults shift
    // from just above the spare (52/53) up to the fault.
    assign start = lower ? idx_q : {6'd26, idx_q[0]};
    assign stop  = lower ? {6'd24, idx_q[0]} : idx_q;

    assign rep_ack     = state_q == ACK;
    assign rep_err     = (state_q == ACK) && err_q;
    assign busy        = state_q != IDLE;
    assign shift_valid = state_q != FILL;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = go ? (rep_clr ? CLEAR : CHECK) : IDLE;
            CHECK:   state_d = bad ? ACK : FILL;
            FILL:    state_d = (ptr_q == end_q) ? ACK : FILL;
            CLEAR:   state_d = ACK;
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            ptr_q     <= '0;
            end_q     <= '0;
            used_q    <= '0;
            err_q     <= 1'b0;
            hold_q    <= 1'b0;
            pad_shift <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= (rep_req || rep_clr) && (hold_q || state_q == ACK);
            case (state_q)
                IDLE: if (go && !rep_clr) idx_q <= rep_idx;
                CHECK: begin
                    err_q <= bad;
                    if (!bad) begin
                        used_q[idx_q[0]] <= 1'b1;
                        ptr_q            <= start;
                        end_q            <= stop;
                    end
                end
                FILL: begin
                    pad_shift[ptr_q] <= 1'b1;
                    ptr_q            <= ptr_q + 7'd2;
                end
                CLEAR: begin
                    pad_shift <= '0;
                    used_q    <= '0;
                    err_q     <= 1'b0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_aib_redundancy_ctrl.sv
// tb_aib_redundancy_ctrl: table-driven check of repair, reject, clear and reset-mid-fill behaviour.
module tb_aib_redundancy_ctrl;
    logic         clk = 1'b0;
    logic         rst_n, rep_req, rep_clr, rep_ack, rep_err, busy, shift_valid;
    logic [6:0]   rep_idx;
    logic [101:0] pad_shift;
    int           nchk = 0, nfail = 0;

    typedef struct {
        logic         clr;
        logic [6:0]   idx;
        logic         err;
        int           n;
        logic [101:0] vec;
    } vec_t;
    vec_t tv[$];

    always #5 clk = ~clk;

    aib_redundancy_ctrl dut (
        .clk(clk), .rst_n(rst_n), .rep_req(rep_req), .rep_clr(rep_clr),
        .rep_idx(rep_idx), .rep_ack(rep_ack), .rep_err(rep_err), .busy(busy),
        .pad_shift(pad_shift), .shift_valid(shift_valid)
    );

    function automatic logic [101:0] pat(input int s, input int e);
        logic [101:0] v = '0;
        for (int i = s; i <= e; i += 2) v[i] = 1'b1;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic txn(input vec_t t, input string nm);
        int cyc = 0, nlow = 0;
        @(negedge clk);
        rep_clr = t.clr;
        rep_req = !t.clr;
        rep_idx = t.idx;
        do begin
            @(posedge clk);
            #1;
            cyc++;
            if (!shift_valid) nlow++;
        end while (!rep_ack && cyc < 60);
        chk({nm, " ack"}, 128'(rep_ack), 128'(1));
        chk({nm, " latency"}, 128'(cyc), 128'(t.n + 2));
        chk({nm, " fill_cycles"}, 128'(nlow), 128'(t.n));
        chk({nm, " err"}, 128'(rep_err), 128'(t.err));
        chk({nm, " valid_busy_in_ack"}, 128'({shift_valid, busy}), 128'(2'b11));
        chk({nm, " vec"}, 128'(pad_shift), 128'(t.vec));
        @(negedge clk);
        rep_req = 1'b0;
        rep_clr = 1'b0;
        rep_idx = 7'h55;
        @(negedge clk);
    endtask

    initial begin
        logic [101:0] e45, e60, e3, e101, e52;
        e45  = pat(45, 49);
        e60  = pat(52, 60);
        e3   = pat(3, 49);
        e101 = pat(53, 101);
        e52  = pat(52, 52);
        tv.push_back('{0, 7'd44,  0, 3,  pat(44, 48)});
        tv.push_back('{1, 7'd0,   0, 0,  '0});
        tv.push_back('{0, 7'd45,  0, 3,  e45});
        tv.push_back('{0, 7'd97,  1, 0,  e45});
        tv.push_back('{1, 7'd0,   0, 0,  '0});
        tv.push_back('{0, 7'd60,  0, 5,  e60});
        tv.push_back('{0, 7'd3,   0, 24, e60 | e3});
        tv.push_back('{0, 7'd4,   1, 0,  e60 | e3});
        tv.push_back('{1, 7'd0,   0, 0,  '0});
        tv.push_back('{0, 7'd0,   1, 0,  '0});
        tv.push_back('{0, 7'd1,   1, 0,  '0});
        tv.push_back('{0, 7'd50,  1, 0,  '0});
        tv.push_back('{0, 7'd51,  1, 0,  '0});
        tv.push_back('{0, 7'd102, 1, 0,  '0});
        tv.push_back('{0, 7'd127, 1, 0,  '0});
        tv.push_back('{0, 7'd101, 0, 25, e101});
        tv.push_back('{0, 7'd52,  0, 1,  e101 | e52});
        tv.push_back('{0, 7'd49,  1, 0,  e101 | e52});
        tv.push_back('{1, 7'd0,   0, 0,  '0});

        rst_n = 1'b0;
        rep_req = 1'b0;
        rep_clr = 1'b0;
        rep_idx = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset outputs", 128'({rep_ack, rep_err, busy, shift_valid}), 128'(4'b0001));
        chk("reset vec", 128'(pad_shift), 128'(0));
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("idle outputs", 128'({rep_ack, rep_err, busy, shift_valid}), 128'(4'b0001));
        chk("idle vec", 128'(pad_shift), 128'(0));

        for (int i = 0; i < tv.size(); i++) txn(tv[i], $sformatf("v%0d_idx%0d", i, tv[i].idx));

        // Clear and repair requested together: clear wins, request is dropped.
        tv[0] = '{0, 7'd44, 0, 3, pat(44, 48)};
        txn(tv[0], "pre_both");
        @(negedge clk);
        rep_req = 1'b1;
        rep_clr = 1'b1;
        rep_idx = 7'd45;
        repeat (2) @(posedge clk);
        #1;
        chk("both ack", 128'({rep_ack, rep_err}), 128'(2'b10));
        chk("both vec", 128'(pad_shift), 128'(0));
        @(negedge clk);
        rep_req = 1'b0;
        rep_clr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("both idle", 128'({busy, pad_shift}), 128'(0));

        // Reset asserted mid-fill of idx=2 discards the partial vector.
        @(negedge clk);
        rep_req = 1'b1;
        rep_idx = 7'd2;
        repeat (8) @(posedge clk);
        #1;
        chk("midfill busy", 128'({busy, shift_valid}), 128'(2'b10));
        rst_n = 1'b0;
        #1;
        chk("midfill reset outputs", 128'({rep_ack, rep_err, busy, shift_valid}), 128'(4'b0001));
        chk("midfill reset vec", 128'(pad_shift), 128'(0));
        @(negedge clk);
        rep_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tv[0] = '{0, 7'd2, 0, 24, pat(2, 48)};
        txn(tv[0], "after_reset_idx2");
        tv[0] = '{1, 7'd0, 0, 0, '0};
        txn(tv[0], "final_clr");

        $display("== %0d vectors applied, %0d miscompares ==", nchk, nfail);
        $finish;
    end
endmodule
